ddc_iq_fifo: RTL and testbench

DDC_IQ_FIFO -- requirements
Module: ddc_iq_fifo

---
 rtl/ddc_iq_fifo_if.sv | 29 ++
 rtl/ddc_iq_fifo.sv | 86 ++++++++
 tb/tb_ddc_iq_fifo.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/ddc_iq_fifo_if.sv
// I/Q stream bus between the halfband cascade output, the FWFT FIFO and its consumer.
// The master drives samples, clear and ready; the slave (the FIFO) returns head data and status.
interface ddc_iq_fifo_if #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0]   i_inph_data;
  logic [WIDTH-1:0]   i_quad_data;
  logic               i_valid;
  logic               i_clear;
  logic               i_ready;
  logic [2*WIDTH-1:0] o_data;
  logic               o_valid;
  logic [LW-1:0]      o_level;
  logic               o_overflow;
  logic [15:0]        o_drop_count;

  modport master (
    output i_inph_data, i_quad_data, i_valid, i_clear, i_ready,
    input  o_data, o_valid, o_level, o_overflow, o_drop_count
  );

  modport slave (
    input  i_inph_data, i_quad_data, i_valid, i_clear, i_ready,
    output o_data, o_valid, o_level, o_overflow, o_drop_count
  );
endinterface

// File: rtl/ddc_iq_fifo.sv
// First-word-fall-through FIFO for packed I/Q pairs with overflow tracking.
// The source cannot be stalled, so pairs arriving while full (and not popping) are dropped and counted.
module ddc_iq_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic            i_clock,
  input  logic            i_reset,
  ddc_iq_fifo_if.slave    bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

  logic [2*WIDTH-1:0] mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic          overflow_q, overflow_d;
  logic [15:0]   drop_count_q, drop_count_d;

  logic full;
  logic pop;
  logic push;
  logic drop;

  always_comb begin
    full = (level_q == FULL_LEVEL);
    pop  = (level_q != '0) && bus.i_ready;
    push = bus.i_valid && (!full || pop);
    drop = bus.i_valid && full && !pop;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    level_d      = level_q;
    overflow_d   = overflow_q;
    drop_count_d = drop_count_q;
    // Clear wins over any push/pop in the same cycle; the incoming pair is not counted.
    if (bus.i_clear) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      level_d      = '0;
      overflow_d   = 1'b0;
      drop_count_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      level_d = level_q + LW'(1);
      else if (pop && !push) level_d = level_q - LW'(1);
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
      end
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      level_q      <= '0;
      overflow_q   <= 1'b0;
      drop_count_q <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      level_q      <= level_d;
      overflow_q   <= overflow_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Storage is deliberately unreset; o_valid gates every read of an unwritten slot.
  always_ff @(posedge i_clock) begin
    if (push && !bus.i_clear) mem[wr_ptr_q] <= {bus.i_quad_data, bus.i_inph_data};
  end

  assign bus.o_data       = mem[rd_ptr_q];
  assign bus.o_valid      = (level_q != '0);
  assign bus.o_level      = level_q;
  assign bus.o_overflow   = overflow_q;
  assign bus.o_drop_count = drop_count_q;
endmodule

// File: tb/tb_ddc_iq_fifo.sv
// Directed table vectors, multi-cycle corner sequences and a scoreboarded random soak
// for ddc_iq_fifo at WIDTH=16, DEPTH=16.
module tb_ddc_iq_fifo;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ddc_iq_fifo_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  ddc_iq_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .i_clock (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        valid;
    logic [15:0] inph;
    logic [15:0] quad;
    logic        ready;
    logic        clear;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic [4:0]  exp_level;
    logic        exp_ovf;
    logic [15:0] exp_drops;
  } vec_t;

  vec_t vecs [11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [15:0] i, input logic [15:0] q,
                       input logic r, input logic c);
    bus.i_valid     = v;
    bus.i_inph_data = i;
    bus.i_quad_data = q;
    bus.i_ready     = r;
    bus.i_clear     = c;
  endtask

  // One clock: inputs already driven at a falling edge, sample at the next falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [31:0] pk(input logic [15:0] i);
    return {i ^ 16'hFFFF, i};
  endfunction

  initial begin
    logic [15:0] exp_seq [16];
    logic [31:0] model_q [$];
    int          model_drops;
    logic        rv, rr, mpop, mfull;
    logic [15:0] ri;

    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    vecs[0]  = '{1'b1, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b1, 32'hABCD1234, 5'd1, 1'b0, 16'd0};
    vecs[1]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 16'd0};
    vecs[2]  = '{1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1, 32'h22221111, 5'd1, 1'b0, 16'd0};
    vecs[3]  = '{1'b1, 16'h3333, 16'h4444, 1'b0, 1'b0, 1'b1, 32'h22221111, 5'd2, 1'b0, 16'd0};
    vecs[4]  = '{1'b1, 16'h5555, 16'h6666, 1'b1, 1'b0, 1'b1, 32'h44443333, 5'd2, 1'b0, 16'd0};
    vecs[5]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b1, 32'h66665555, 5'd1, 1'b0, 16'd0};
    vecs[6]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 16'd0};
    vecs[7]  = '{1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 32'h0,        5'd0, 1'b0, 16'd0};
    vecs[8]  = '{1'b1, 16'h7777, 16'h8888, 1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 16'd0};
    vecs[9]  = '{1'b1, 16'h9999, 16'hAAAA, 1'b0, 1'b0, 1'b1, 32'hAAAA9999, 5'd1, 1'b0, 16'd0};
    vecs[10] = '{1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 32'h0,        5'd0, 1'b0, 16'd0};

    // Reset state, held across clock edges
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(bus.o_valid), 32'd0);
    chk("rst_level", 32'(bus.o_level), 32'd0);
    chk("rst_ovf",   32'(bus.o_overflow), 32'd0);
    chk("rst_drops", 32'(bus.o_drop_count), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) begin
      drive(vecs[k].valid, vecs[k].inph, vecs[k].quad, vecs[k].ready, vecs[k].clear);
      step();
      $display("vec %0d: valid=%0b data=%h level=%0d ovf=%0b drops=%0d", k,
               bus.o_valid, bus.o_data, bus.o_level, bus.o_overflow, bus.o_drop_count);
      chk($sformatf("vec%0d_valid", k), 32'(bus.o_valid), 32'(vecs[k].exp_valid));
      chk($sformatf("vec%0d_level", k), 32'(bus.o_level), 32'(vecs[k].exp_level));
      chk($sformatf("vec%0d_ovf", k),   32'(bus.o_overflow), 32'(vecs[k].exp_ovf));
      chk($sformatf("vec%0d_drops", k), 32'(bus.o_drop_count), 32'(vecs[k].exp_drops));
      if (vecs[k].exp_valid) chk($sformatf("vec%0d_data", k), bus.o_data, vecs[k].exp_data);
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);

    // Fill past full with no consumer: 16 stored, 4 dropped
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'(i), 16'(i) ^ 16'hFFFF, 1'b0, 1'b0);
      step();
    end
    $display("fill: level=%0d ovf=%0b drops=%0d", bus.o_level, bus.o_overflow, bus.o_drop_count);
    chk("fill_level", 32'(bus.o_level), 32'd16);
    chk("fill_ovf",   32'(bus.o_overflow), 32'd1);
    chk("fill_drops", 32'(bus.o_drop_count), 32'd4);
    chk("fill_head",  bus.o_data, pk(16'd0));

    // Full with simultaneous push and pop: no drops, level pinned at DEPTH
    for (int k = 0; k < 8; k++) begin
      drive(1'b1, 16'(20 + k), 16'(20 + k) ^ 16'hFFFF, 1'b1, 1'b0);
      chk($sformatf("fullpop%0d_head", k), bus.o_data, pk(16'(k)));
      step();
      $display("fullpop %0d: level=%0d drops=%0d", k, bus.o_level, bus.o_drop_count);
      chk($sformatf("fullpop%0d_level", k), 32'(bus.o_level), 32'd16);
    end
    chk("fullpop_drops", 32'(bus.o_drop_count), 32'd4);

    // Drain across the pointer wrap
    for (int k = 0; k < 8; k++) exp_seq[k] = 16'(8 + k);
    for (int k = 0; k < 8; k++) exp_seq[8 + k] = 16'(20 + k);
    for (int k = 0; k < 16; k++) begin
      drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
      chk($sformatf("drain%0d_valid", k), 32'(bus.o_valid), 32'd1);
      chk($sformatf("drain%0d_data", k), bus.o_data, pk(exp_seq[k]));
      $display("drain %0d: data=%h", k, bus.o_data);
      step();
    end
    chk("drain_level", 32'(bus.o_level), 32'd0);
    chk("drain_valid", 32'(bus.o_valid), 32'd0);

    // Clear with a simultaneous push wipes data and statistics
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 16'(16'h500 + k), 16'(16'h500 + k) ^ 16'hFFFF, 1'b0, 1'b0);
      step();
    end
    chk("preclr_level", 32'(bus.o_level), 32'd5);
    chk("preclr_ovf",   32'(bus.o_overflow), 32'd1);
    drive(1'b1, 16'hDEAD, 16'hBEEF, 1'b0, 1'b1);
    step();
    $display("clear: level=%0d valid=%0b ovf=%0b drops=%0d", bus.o_level, bus.o_valid,
             bus.o_overflow, bus.o_drop_count);
    chk("clr_level", 32'(bus.o_level), 32'd0);
    chk("clr_valid", 32'(bus.o_valid), 32'd0);
    chk("clr_ovf",   32'(bus.o_overflow), 32'd0);
    chk("clr_drops", 32'(bus.o_drop_count), 32'd0);

    // Asynchronous reset between edges with entries stored
    for (int k = 0; k < 7; k++) begin
      drive(1'b1, 16'(16'h700 + k), 16'(16'h700 + k) ^ 16'hFFFF, 1'b0, 1'b0);
      step();
    end
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    chk("prerst_level", 32'(bus.o_level), 32'd7);
    #2 rst_n = 1'b0;
    #1;
    $display("async reset: level=%0d valid=%0b", bus.o_level, bus.o_valid);
    chk("arst_valid", 32'(bus.o_valid), 32'd0);
    chk("arst_level", 32'(bus.o_level), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 16'h0BEE, 16'h0BEE ^ 16'hFFFF, 1'b0, 1'b0);
    step();
    chk("postrst_level", 32'(bus.o_level), 32'd1);
    chk("postrst_data",  bus.o_data, pk(16'h0BEE));
    drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    step();

    // Random soak against a queue model
    model_drops = 0;
    for (int c = 0; c < 10000; c++) begin
      rv = 1'($urandom_range(1));
      rr = 1'($urandom_range(1));
      ri = 16'($urandom);
      drive(rv, ri, ri ^ 16'hFFFF, rr, 1'b0);
      chk("soak_valid", 32'(bus.o_valid), 32'(model_q.size() != 0));
      chk("soak_level", 32'(bus.o_level), 32'(model_q.size()));
      if (model_q.size() != 0) chk("soak_data", bus.o_data, model_q[0]);
      mfull = (model_q.size() == DEPTH);
      mpop  = (model_q.size() != 0) && rr;
      if (mpop) void'(model_q.pop_front());
      if (rv && (!mfull || mpop)) model_q.push_back(pk(ri));
      else if (rv && model_drops < 16'hFFFF) model_drops++;
      step();
    end
    $display("soak: level=%0d drops=%0d model_drops=%0d", bus.o_level, bus.o_drop_count, model_drops);
    chk("soak_drops", 32'(bus.o_drop_count), 32'(model_drops));
    chk("soak_ovf",   32'(bus.o_overflow), 32'(model_drops != 0));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
